// File: rtl/cpu_pkg.sv
// Shared opcode and controller state encodings for the CPU datapath and control.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_HLT  = 3'b000,
    OP_SKZ  = 3'b001,
    OP_ADD  = 3'b010,
    OP_ANDD = 3'b011,
    OP_XORR = 3'b100,
    OP_LDA  = 3'b101,
    OP_STO  = 3'b110,
    OP_JMP  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_HI = 3'd1,
    ST_FETCH_LO = 3'd2,
    ST_DECODE   = 3'd3,
    ST_EXEC     = 3'd4,
    ST_WRITE    = 3'd5,
    ST_HALT     = 3'd6,
    ST_SPARE    = 3'd7
  } state_t;

  // Opcodes that read memory into the ALU and land the result in the accumulator.
  function automatic logic is_alu_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Instruction sequencer: fetch (2 bytes), decode, execute, write-back, halt.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       alu_ena,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt,
  output logic       busy
);

  state_t  state;
  state_t  state_next;
  opcode_t op;

  assign op = opcode_t'(opcode);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and output decode; outputs are held low while reset is asserted.
  always_comb begin
    state_next  = ST_IDLE;
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    alu_ena     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    busy        = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_IDLE: begin
          state_next = ena ? ST_FETCH_HI : ST_IDLE;
        end
        ST_FETCH_HI: begin
          rd         = 1'b1;
          load_ir    = 1'b1;
          busy       = 1'b1;
          state_next = ST_FETCH_LO;
        end
        ST_FETCH_LO: begin
          rd         = 1'b1;
          load_ir    = 1'b1;
          inc_pc     = 1'b1;
          busy       = 1'b1;
          state_next = ST_DECODE;
        end
        ST_DECODE: begin
          inc_pc     = 1'b1;
          busy       = 1'b1;
          state_next = (op == OP_HLT) ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          busy       = 1'b1;
          state_next = ST_WRITE;
          if (is_alu_op(op)) begin
            rd      = 1'b1;
            alu_ena = 1'b1;
          end else if (op == OP_STO) begin
            datactl_ena = 1'b1;
          end else if (op == OP_JMP) begin
            load_pc = 1'b1;
          end else if (op == OP_SKZ) begin
            inc_pc = zero;
          end
        end
        ST_WRITE: begin
          busy       = 1'b1;
          state_next = ena ? ST_FETCH_HI : ST_IDLE;
          if (is_alu_op(op)) begin
            rd       = 1'b1;
            load_acc = 1'b1;
          end else if (op == OP_STO) begin
            wr          = 1'b1;
            datactl_ena = 1'b1;
          end else if (op == OP_JMP) begin
            load_pc = 1'b1;
          end else if (op == OP_SKZ) begin
            inc_pc = zero;
          end
        end
        ST_HALT: begin
          halt       = 1'b1;
          state_next = ena ? ST_HALT : ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed, table-driven check of the cpu_controller sequencing and decode.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt, busy;
  logic [9:0] outs;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic        mon_on;

  // Output vector order: rd wr load_ir inc_pc load_pc alu_ena load_acc datactl_ena halt busy
  localparam logic [9:0] O_IDLE   = 10'b0000000000;
  localparam logic [9:0] O_FHI    = 10'b1010000001;
  localparam logic [9:0] O_FLO    = 10'b1011000001;
  localparam logic [9:0] O_DEC    = 10'b0001000001;
  localparam logic [9:0] O_EX_ALU = 10'b1000010001;
  localparam logic [9:0] O_WR_ALU = 10'b1000001001;
  localparam logic [9:0] O_EX_STO = 10'b0000000101;
  localparam logic [9:0] O_WR_STO = 10'b0100000101;
  localparam logic [9:0] O_JMP    = 10'b0000100001;
  localparam logic [9:0] O_SKZ_Z1 = 10'b0001000001;
  localparam logic [9:0] O_SKZ_Z0 = 10'b0000000001;
  localparam logic [9:0] O_HALT   = 10'b0000000010;

  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [2:0] op;
    logic       zero;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  cpu_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .rd          (rd),
    .wr          (wr),
    .load_ir     (load_ir),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .alu_ena     (alu_ena),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt),
    .busy        (busy)
  );

  assign outs = {rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle invariants: bus exclusivity, PC control exclusivity, spare state unreachable.
  always @(posedge clk) begin
    #3;
    if (mon_on) begin
      n_cmp++;
      if (rd && wr) begin
        n_bad++;
        $display("FAIL rd_wr_excl t=%0t rd=%0b wr=%0b required not both", $time, rd, wr);
      end
      n_cmp++;
      if (wr && !datactl_ena) begin
        n_bad++;
        $display("FAIL wr_needs_datactl t=%0t wr=%0b datactl_ena=%0b required datactl_ena=1", $time, wr, datactl_ena);
      end
      n_cmp++;
      if (load_pc && inc_pc) begin
        n_bad++;
        $display("FAIL pc_excl t=%0t load_pc=%0b inc_pc=%0b required not both", $time, load_pc, inc_pc);
      end
      n_cmp++;
      if (dut.state == ST_SPARE) begin
        n_bad++;
        $display("FAIL spare_state t=%0t state=%0d required != 7", $time, dut.state);
      end
    end
  end

  task automatic add(input logic r, input logic e, input logic [2:0] o, input logic z, input logic [9:0] x);
    vec_t v;
    v.rst_n = r; v.ena = e; v.op = o; v.zero = z; v.exp = x;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after the falling edge, then compare the decoded outputs.
  task automatic cycle(input string name, input logic r, input logic e, input logic [2:0] o,
                       input logic z, input logic [9:0] x);
    @(negedge clk);
    rst_n = r; ena = e; opcode = o; zero = z;
    #1;
    n_cmp++;
    if (outs !== x) begin
      n_bad++;
      $display("FAIL %s t=%0t outs=%b required=%b", name, $time, outs, x);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; mon_on = 1'b0;
    rst_n = 1'b0; ena = 1'b0; opcode = OP_HLT; zero = 1'b0;

    // ADD then back-to-back SKZ(z=1), SKZ(z=0), STO, JMP
    add(1, 1, OP_ADD, 0, O_IDLE);
    add(1, 1, OP_ADD, 0, O_FHI);
    add(1, 1, OP_ADD, 0, O_FLO);
    add(1, 1, OP_ADD, 0, O_DEC);
    add(1, 1, OP_ADD, 0, O_EX_ALU);
    add(1, 1, OP_ADD, 0, O_WR_ALU);
    add(1, 1, OP_SKZ, 1, O_FHI);
    add(1, 1, OP_SKZ, 1, O_FLO);
    add(1, 1, OP_SKZ, 1, O_DEC);
    add(1, 1, OP_SKZ, 1, O_SKZ_Z1);
    add(1, 1, OP_SKZ, 1, O_SKZ_Z1);
    add(1, 1, OP_SKZ, 0, O_FHI);
    add(1, 1, OP_SKZ, 0, O_FLO);
    add(1, 1, OP_SKZ, 0, O_DEC);
    add(1, 1, OP_SKZ, 0, O_SKZ_Z0);
    add(1, 1, OP_SKZ, 0, O_SKZ_Z0);
    add(1, 1, OP_STO, 0, O_FHI);
    add(1, 1, OP_STO, 0, O_FLO);
    add(1, 1, OP_STO, 0, O_DEC);
    add(1, 1, OP_STO, 0, O_EX_STO);
    add(1, 1, OP_STO, 0, O_WR_STO);
    add(1, 1, OP_JMP, 1, O_FHI);
    add(1, 1, OP_JMP, 1, O_FLO);
    add(1, 1, OP_JMP, 1, O_DEC);
    add(1, 1, OP_JMP, 1, O_JMP);
    add(1, 1, OP_JMP, 1, O_JMP);
    // ANDD with ena dropped in FETCH_LO: completes, then parks in IDLE
    add(1, 1, OP_ANDD, 0, O_FHI);
    add(1, 0, OP_ANDD, 0, O_FLO);
    add(1, 0, OP_ANDD, 0, O_DEC);
    add(1, 0, OP_ANDD, 0, O_EX_ALU);
    add(1, 0, OP_ANDD, 0, O_WR_ALU);
    add(1, 0, OP_ANDD, 0, O_IDLE);
    add(1, 1, OP_HLT, 0, O_IDLE);
    // HLT: halt held while ena=1, released to IDLE when ena drops
    add(1, 1, OP_HLT, 0, O_FHI);
    add(1, 1, OP_HLT, 0, O_FLO);
    add(1, 1, OP_HLT, 0, O_DEC);
    add(1, 1, OP_HLT, 0, O_HALT);
    add(1, 1, OP_HLT, 0, O_HALT);
    add(1, 0, OP_HLT, 0, O_HALT);
    add(1, 0, OP_HLT, 0, O_IDLE);
    // XORR with reset asserted in EXEC
    add(1, 1, OP_XORR, 0, O_IDLE);
    add(1, 1, OP_XORR, 0, O_FHI);
    add(1, 1, OP_XORR, 0, O_FLO);
    add(1, 1, OP_XORR, 0, O_DEC);
    add(0, 1, OP_XORR, 0, O_IDLE);
    add(1, 0, OP_XORR, 0, O_IDLE);
    // Reset wins over ena
    add(0, 1, OP_LDA, 0, O_IDLE);
    add(1, 1, OP_LDA, 0, O_IDLE);
    add(1, 1, OP_LDA, 0, O_FHI);
    add(1, 1, OP_LDA, 0, O_FLO);
    add(1, 1, OP_LDA, 0, O_DEC);
    add(1, 1, OP_LDA, 0, O_EX_ALU);
    add(1, 0, OP_LDA, 0, O_WR_ALU);
    add(1, 0, OP_LDA, 0, O_IDLE);

    // Reset phase: outputs low during reset
    cycle("reset_0", 0, 0, OP_HLT, 0, O_IDLE);
    cycle("reset_1", 0, 1, OP_ADD, 0, O_IDLE);
    mon_on = 1'b1;

    foreach (vecs[i]) begin
      cycle($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].ena, vecs[i].op, vecs[i].zero, vecs[i].exp);
    end

    // Reset taken while halted, then restart with ena already high
    cycle("hr_idle", 1, 1, OP_HLT, 0, O_IDLE);
    cycle("hr_fhi",  1, 1, OP_HLT, 0, O_FHI);
    cycle("hr_flo",  1, 1, OP_HLT, 0, O_FLO);
    cycle("hr_dec",  1, 1, OP_HLT, 0, O_DEC);
    cycle("hr_halt", 1, 1, OP_HLT, 0, O_HALT);
    cycle("hr_rst",  0, 1, OP_HLT, 0, O_IDLE);
    cycle("hr_post", 1, 1, OP_STO, 0, O_IDLE);
    cycle("hr_fhi2", 1, 1, OP_STO, 0, O_FHI);
    cycle("hr_flo2", 1, 1, OP_STO, 0, O_FLO);
    cycle("hr_dec2", 1, 0, OP_STO, 0, O_DEC);
    cycle("hr_ex2",  1, 0, OP_STO, 0, O_EX_STO);
    cycle("hr_wr2",  1, 0, OP_STO, 0, O_WR_STO);
    cycle("hr_park", 1, 0, OP_STO, 0, O_IDLE);
    // Opcode/zero outside DECODE/EXEC/WRITE must not disturb fetch
    cycle("dc_idle", 1, 1, OP_JMP, 1, O_IDLE);
    cycle("dc_fhi",  1, 1, OP_HLT, 1, O_FHI);
    cycle("dc_flo",  1, 1, OP_STO, 0, O_FLO);
    cycle("dc_dec",  1, 1, OP_JMP, 0, O_DEC);
    cycle("dc_ex",   1, 1, OP_JMP, 0, O_JMP);
    cycle("dc_wr",   1, 0, OP_JMP, 0, O_JMP);
    cycle("dc_park", 1, 0, OP_JMP, 0, O_IDLE);

    @(negedge clk);
    mon_on = 1'b0;
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: ena  input  1  run enable from top level.
REQ-004 SHALL have port: opcode  input  3  instruction opcode from instruction register; HLT=000 SKZ=001 ADD=010 ANDD=011 XORR=100 LDA=101 STO=110 JMP=111.
REQ-005 SHALL have port: zero  input  1  accumulator-is-zero flag from ALU.
REQ-006 SHALL have outputs, 1 bit each: rd (memory read), wr (memory write), load_ir (capture instruction byte), inc_pc (PC increment), load_pc (PC load from operand), alu_ena (ALU evaluate), load_acc (accumulator capture), datactl_ena (drive accumulator onto data bus), halt (processor stopped), busy (instruction in flight).

Function
REQ-007 SHALL implement an 8-entry 3-bit state register: IDLE=0, FETCH_HI=1, FETCH_LO=2, DECODE=3, EXEC=4, WRITE=5, HALT=6, spare=7.
REQ-008 SHALL decode outputs combinationally from current state and opcode; all outputs 0 unless listed below.
REQ-009 IDLE: all outputs 0; next = FETCH_HI when ena=1, else IDLE.
REQ-010 FETCH_HI: rd=1, load_ir=1, busy=1; next = FETCH_LO.
REQ-011 FETCH_LO: rd=1, load_ir=1, inc_pc=1, busy=1; next = DECODE.
REQ-012 DECODE: inc_pc=1, busy=1; next = HALT if opcode=HLT, else EXEC.
REQ-013 EXEC: busy=1; ADD/ANDD/XORR/LDA -> rd=1, alu_ena=1; STO -> datactl_ena=1; JMP -> load_pc=1; SKZ -> inc_pc=zero; next = WRITE.
REQ-014 WRITE: busy=1; ADD/ANDD/XORR/LDA -> rd=1, load_acc=1; STO -> wr=1, datactl_ena=1; JMP -> load_pc=1; SKZ -> inc_pc=zero; next = FETCH_HI if ena=1, else IDLE.
REQ-015 HALT: halt=1, busy=0; next = IDLE when ena=0, else HALT.
REQ-016 Spare state 7 SHALL drive all outputs 0 and transition to IDLE next cycle.
REQ-017 Non-HLT instruction SHALL take exactly 5 cycles FETCH_HI..WRITE; back-to-back instructions with ena held SHALL have no idle cycle.
REQ-018 ena deassert mid-instruction SHALL NOT abort it; instruction completes, controller parks in IDLE after WRITE.
REQ-019 opcode and zero SHALL be sampled only in DECODE, EXEC and WRITE; values in other states are don't-care.
REQ-020 wr and rd SHALL never be 1 in the same cycle; wr SHALL be 1 only when datactl_ena=1.
REQ-021 load_pc and inc_pc SHALL never be 1 in the same cycle.
REQ-022 First fetch SHALL begin (rd=1) exactly one cycle after ena is sampled 1 in IDLE.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force state to IDLE, regardless of current state, including mid-instruction and HALT.
REQ-024 During and one cycle after reset all outputs SHALL be 0.
REQ-025 Reset SHALL have priority over ena.

Structure
REQ-026 Opcode constants and state encodings SHALL live in shared package cpu_pkg, also used by the ALU.
REQ-027 SHALL be a single module, no sub-module: one sequential state register, one combinational next-state/output decode.

Verification
REQ-028 Reset then ena=1, opcode=ADD: rd+load_ir for 2 cycles, inc_pc in FETCH_LO and DECODE, alu_ena in EXEC, load_acc in WRITE, FETCH_HI on 6th cycle.
REQ-029 opcode=SKZ, zero=1 then zero=0: inc_pc high in EXEC and WRITE for zero=1, low in both for zero=0.
REQ-030 opcode=STO: datactl_ena in EXEC and WRITE, wr only in WRITE, rd never in EXEC/WRITE; opcode=JMP: load_pc in EXEC and WRITE, inc_pc low there.
REQ-031 opcode=HLT with ena=1: halt=1 from cycle after DECODE and held; ena dropped -> IDLE next cycle, halt=0.
REQ-032 ena dropped in FETCH_LO: instruction completes through WRITE then IDLE; rst_n=0 in EXEC: IDLE and all outputs 0 next cycle.
REQ-033 Assertions run in all tests: REQ-020, REQ-021, state never 7 after reset.
